// File: rtl/nco_clkgen_multi_pkg.sv
// -----------------------------------------------------------------------------
// clkgen_pkg
//   Shared definitions for the multi-channel NCO clock generator.
//   - ACC_W_DEFAULT : default phase-accumulator width
//   - acc_t         : accumulator / increment word at the default width
//   - cfg_state_e   : reconfiguration FSM states
//   - calc_inc()    : increment for a wanted output frequency, rounded to
//                     nearest (f_out = f_ref * inc / 2^ACC_W)
// -----------------------------------------------------------------------------
package clkgen_pkg;

    localparam int ACC_W_DEFAULT = 16;

    typedef logic [ACC_W_DEFAULT-1:0] acc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DROP = 2'd2
    } cfg_state_e;

    // Elaboration-time helper: 50 MHz -> 1.171875 MHz yields 1536.
    function automatic acc_t calc_inc(input longint unsigned ref_hz,
                                      input longint unsigned out_hz);
        longint unsigned num;
        num = (out_hz << ACC_W_DEFAULT) + (ref_hz >> 1);
        return acc_t'(num / ref_hz);
    endfunction

endpackage

// File: rtl/nco_clkgen_multi_if.sv
// -----------------------------------------------------------------------------
// nco_clkgen_multi_if
//   Reconfiguration request channel.
//   Handshake: a request (cfg_chan, cfg_inc) transfers on a refclk rising edge
//   where cfg_valid and cfg_ready are both 1. The master holds cfg_valid and
//   the payload stable until that edge; cfg_ready does not depend on
//   cfg_valid.
//   Signals:
//     cfg_valid  master->slave  request present
//     cfg_ready  slave->master  block can accept a request
//     cfg_chan   master->slave  target channel index
//     cfg_inc    master->slave  new increment for the target channel
// -----------------------------------------------------------------------------
interface nco_clkgen_multi_if #(
    parameter int ACC_W = 16
) ();

    logic             cfg_valid;
    logic             cfg_ready;
    logic [2:0]       cfg_chan;
    logic [ACC_W-1:0] cfg_inc;

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_inc,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_inc,
        output cfg_ready
    );

endinterface

// File: rtl/nco_clkgen_multi_chan.sv
// -----------------------------------------------------------------------------
// nco_chan
//   One phase-accumulator NCO channel.
//   Each cycle acc <= acc + inc (mod 2^ACC_W). The output clock is the
//   registered MSB of the new accumulator value; the strobe marks the cycle
//   in which that registered MSB rises.
//   Ports:
//     clk        refclk
//     rst        asynchronous active-high reset
//     apply_i    load new_inc_i into the increment register this cycle
//     new_inc_i  increment to load when apply_i is high
//     outclk_o   generated clock (registered MSB)
//     outstb_o   one-cycle pulse coincident with each outclk_o rise
//     wrap_o     combinational: the add in this cycle carries out
//     inc_o      current increment
// -----------------------------------------------------------------------------
module nco_chan #(
    parameter int               ACC_W      = 16,
    parameter logic [ACC_W-1:0] INIT_INC   = '0,
    parameter logic [ACC_W-1:0] INIT_PHASE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             apply_i,
    input  logic [ACC_W-1:0] new_inc_i,
    output logic             outclk_o,
    output logic             outstb_o,
    output logic             wrap_o,
    output logic [ACC_W-1:0] inc_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic             outclk_q, outclk_d;
    logic             outstb_q, outstb_d;
    logic [ACC_W:0]   sum;

    always_comb begin
        sum      = {1'b0, acc_q} + {1'b0, inc_q};
        acc_d    = sum[ACC_W-1:0];
        wrap_o   = sum[ACC_W];
        // The add in the apply cycle still uses the old increment; the new
        // one takes effect from the following cycle.
        inc_d    = apply_i ? new_inc_i : inc_q;
        outclk_d = acc_d[ACC_W-1];
        outstb_d = outclk_d & ~outclk_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= INIT_PHASE;
            inc_q    <= INIT_INC;
            outclk_q <= 1'b0;
            outstb_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            inc_q    <= inc_d;
            outclk_q <= outclk_d;
            outstb_q <= outstb_d;
        end
    end

    assign outclk_o = outclk_q;
    assign outstb_o = outstb_q;
    assign inc_o    = inc_q;

endmodule

// File: rtl/nco_clkgen_multi.sv
// -----------------------------------------------------------------------------
// nco_clkgen_multi
//   Multi-channel digital clock generator. NUM_CLKS NCO channels share one
//   refclk; a small FSM retunes one channel at a time, applying the new
//   increment on that channel's accumulator wrap so the output never sees a
//   runt pulse beyond normal NCO jitter. A lock counter counts channel-0
//   rising strobes after the last applied configuration.
//   Ports:
//     refclk       sole clock
//     rst          asynchronous active-high reset
//     cfg          reconfiguration request channel (slave side)
//     outclk       generated clocks
//     outstb       one-refclk strobes on each outclk rise
//     locked       LOCK_EDGES channel-0 strobes seen since last apply/reset
//     cfg_state_o  current reconfiguration FSM state (debug)
// -----------------------------------------------------------------------------
module nco_clkgen_multi
    import clkgen_pkg::*;
#(
    parameter int                        NUM_CLKS   = 2,
    parameter int                        ACC_W      = ACC_W_DEFAULT,
    parameter logic [NUM_CLKS*ACC_W-1:0] INIT_INC   = {16'd16384, 16'd1536},
    parameter logic [NUM_CLKS*ACC_W-1:0] INIT_PHASE = {16'd0, 16'd0},
    parameter int                        LOCK_EDGES = 4
) (
    input  logic                refclk,
    input  logic                rst,
    nco_clkgen_multi_if.slave   cfg,
    output logic [NUM_CLKS-1:0] outclk,
    output logic [NUM_CLKS-1:0] outstb,
    output logic                locked,
    output cfg_state_e          cfg_state_o
);

    localparam logic [7:0] LOCK_CNT = 8'(LOCK_EDGES);

    cfg_state_e       state_q, state_d;
    logic [2:0]       chan_q, chan_d;
    logic [ACC_W-1:0] newinc_q, newinc_d;
    logic [7:0]       cnt_q, cnt_d;

    logic [NUM_CLKS-1:0] apply;
    logic [NUM_CLKS-1:0] wrap;
    logic [ACC_W-1:0]    inc_w [NUM_CLKS];
    logic                any_apply;

    for (genvar i = 0; i < NUM_CLKS; i++) begin : g_chan
        nco_chan #(
            .ACC_W      (ACC_W),
            .INIT_INC   (INIT_INC[i*ACC_W +: ACC_W]),
            .INIT_PHASE (INIT_PHASE[i*ACC_W +: ACC_W])
        ) u_chan (
            .clk       (refclk),
            .rst       (rst),
            .apply_i   (apply[i]),
            .new_inc_i (newinc_q),
            .outclk_o  (outclk[i]),
            .outstb_o  (outstb[i]),
            .wrap_o    (wrap[i]),
            .inc_o     (inc_w[i])
        );

        // A frozen channel (inc 0) never wraps, so it takes the new value
        // straight away instead of waiting forever.
        assign apply[i] = (state_q == PEND) && (chan_q == 3'(i)) &&
                          (wrap[i] || (inc_w[i] == '0));
    end

    assign any_apply = |apply;

    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        newinc_d = newinc_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (cfg.cfg_valid) begin
                    if (int'(cfg.cfg_chan) >= NUM_CLKS) begin
                        state_d = DROP;
                    end else begin
                        state_d  = PEND;
                        chan_d   = cfg.cfg_chan;
                        newinc_d = cfg.cfg_inc;
                    end
                end
            end
            PEND: begin
                if (any_apply) begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An apply restarts lock acquisition in the same cycle.
        if (any_apply) begin
            cnt_d = '0;
        end else if (outstb[0] && (cnt_q != LOCK_CNT)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            chan_q   <= '0;
            newinc_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            chan_q   <= chan_d;
            newinc_q <= newinc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cfg.cfg_ready = (state_q == IDLE);
    assign locked        = (cnt_q == LOCK_CNT) && (inc_w[0] != '0);
    assign cfg_state_o   = state_q;

endmodule

// File: tb/tb_nco_clkgen_multi.sv
module tb_nco_clkgen_multi;
  import clkgen_pkg::*;

  localparam int N    = 2;
  localparam int W    = 16;
  localparam int LOCK = 4;
  localparam int MOD  = 65536;
  localparam int HALF = 32768;
  localparam int EW   = 2 * N + 2;

  // ---------------- clock / reset ----------------
  logic refclk = 1'b0;
  logic rst    = 1'b1;
  always #5 refclk = ~refclk;

  nco_clkgen_multi_if #(.ACC_W(W)) cfg_if ();

  logic [N-1:0] outclk;
  logic [N-1:0] outstb;
  logic         locked;
  cfg_state_e   cfg_state;

  nco_clkgen_multi #(
    .NUM_CLKS   (N),
    .ACC_W      (W),
    .INIT_INC   ({16'd16384, 16'd1536}),
    .INIT_PHASE ({16'd0, 16'd0}),
    .LOCK_EDGES (LOCK)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .cfg         (cfg_if),
    .outclk      (outclk),
    .outstb      (outstb),
    .locked      (locked),
    .cfg_state_o (cfg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int stb0_cnt = 0;
  int stb1_cnt = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Behavioural view: integer phases, wrap when the sum reaches 2^W,
  // a request waits for its channel's wrap (or applies at once if frozen).
  int m_acc[N];
  int m_inc[N];
  bit m_clk[N];
  bit m_stb[N];
  int m_cnt;
  bit m_pend, m_drop;
  int m_chan, m_newinc;

  function automatic logic [EW-1:0] reset_outputs();
    return {1'b1, 1'b0, {N{1'b0}}, {N{1'b0}}};
  endfunction

  task automatic model_reset();
    m_acc[0] = 0;    m_acc[1] = 0;
    m_inc[0] = 1536; m_inc[1] = 16384;
    for (int i = 0; i < N; i++) begin
      m_clk[i] = 1'b0;
      m_stb[i] = 1'b0;
    end
    m_cnt = 0; m_pend = 0; m_drop = 0; m_chan = 0; m_newinc = 0;
  endtask

  task automatic model_step();
    bit wrap[N];
    bit applied;
    bit prev_stb0;
    bit nclk;
    int sum;
    logic [EW-1:0] e;
    prev_stb0 = m_stb[0];
    for (int i = 0; i < N; i++) begin
      sum      = m_acc[i] + m_inc[i];
      wrap[i]  = (sum >= MOD);
      m_acc[i] = sum % MOD;
    end
    applied = m_pend && (wrap[m_chan] || m_inc[m_chan] == 0);
    for (int i = 0; i < N; i++) begin
      nclk     = (m_acc[i] >= HALF);
      m_stb[i] = nclk && !m_clk[i];
      m_clk[i] = nclk;
    end
    if (applied) m_cnt = 0;
    else if (prev_stb0 && m_cnt < LOCK) m_cnt++;
    if (applied) begin
      m_inc[m_chan] = m_newinc;
      m_pend = 0;
    end else if (m_drop) begin
      m_drop = 0;
    end else if (!m_pend && cfg_if.cfg_valid) begin
      if (int'(cfg_if.cfg_chan) >= N) m_drop = 1;
      else begin
        m_pend   = 1;
        m_chan   = int'(cfg_if.cfg_chan);
        m_newinc = int'(cfg_if.cfg_inc);
      end
    end
    e[N-1:0]   = {m_clk[1], m_clk[0]};
    e[2*N-1:N] = {m_stb[1], m_stb[0]};
    e[2*N]     = (m_cnt == LOCK) && (m_inc[0] != 0);
    e[2*N+1]   = !m_pend && !m_drop;
    exp_q.push_back(e);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge refclk or posedge rst);
      if (rst) begin
        model_reset();
        exp_q.delete();
      end else begin
        model_step();
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EW-1:0] act;
    logic [EW-1:0] exp;
    forever begin
      @(negedge refclk);
      act = {cfg_if.cfg_ready, locked, outstb, outclk};
      if (outstb[0]) stb0_cnt++;
      if (outstb[1]) stb1_cnt++;
      if (rst || exp_q.size() == 0) exp = reset_outputs();
      else exp = exp_q.pop_front();
      check(rst ? "reset_outputs" : "outputs", 32'(act), 32'(exp));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge refclk);
    #2;
  endtask

  task automatic send_cfg(input int ch, input int v);
    logic [31:0] vv;
    logic [31:0] cc;
    bit got;
    vv = 32'(v);
    cc = 32'(ch);
    @(posedge refclk); #2;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_chan  = cc[2:0];
    cfg_if.cfg_inc   = vv[W-1:0];
    got = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      if (cfg_if.cfg_ready) got = 1;
      @(posedge refclk); #2;
    end
    cfg_if.cfg_valid = 1'b0;
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL cfg_handshake_timeout: got no ready expected ready within 400 cycles");
    end
  endtask

  task automatic pulse_reset();
    @(posedge refclk); #2;
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    stb0_cnt = 0;
    stb1_cnt = 0;
  endtask

  task automatic check_default_strobes();
    cycles(128);
    check("ch0_strobes_128", 32'(stb0_cnt), 32'd3);
    check("ch1_strobes_128", 32'(stb1_cnt), 32'd32);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_chan  = '0;
    cfg_if.cfg_inc   = '0;
    check("calc_inc_50M_1M171875", 32'(calc_inc(64'd50_000_000, 64'd1_171_875)), 32'd1536);
    cycles(3);
    rst = 1'b0;
    stb0_cnt = 0;
    stb1_cnt = 0;
    check_default_strobes();
    cycles(100);                       // reach lock
    check("locked_default", 32'(locked), 32'd1);

    send_cfg(1, 8192);                 // retune ch1 while locked
    cycles(200);
    send_cfg(5, 1234);                 // out-of-range channel is dropped
    cycles(20);
    check("locked_after_drop", 32'(locked), 32'd1);

    send_cfg(0, 0);                    // freeze ch0
    cycles(2);
    stb0_cnt = 0;
    cycles(200);
    check("ch0_frozen_strobes", 32'(stb0_cnt), 32'd0);
    check("ch0_frozen_locked", 32'(locked), 32'd0);
    send_cfg(0, 1536);                 // applies immediately, relocks
    cycles(250);
    check("relocked", 32'(locked), 32'd1);

    for (int r = 0; r < 12; r++) begin
      send_cfg($urandom_range(0, 7), $urandom_range(2048, 40000));
      cycles($urandom_range(0, 60));
    end

    send_cfg(1, 2048);
    cycles(40);
    send_cfg(1, 12345);                // leaves FSM pending on ch1
    rst = 1'b1;                        // asynchronous reset mid-request
    cycles(2);
    rst = 1'b0;
    stb0_cnt = 0;
    stb1_cnt = 0;
    check_default_strobes();           // INIT_INC restored, request lost

    pulse_reset();
    check_default_strobes();
    cycles(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish by 1000000");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
